reorder_buffer: RTL and testbench

- In-order retirement stage of the out-of-order core, sized for 2**ROB_WIDTH entries.
- Inputs: allocates entries from the instruction unit at issue, and captures results broadcast by the reservation station ALU and the load & store buffer.
- Commit: retires completed entries in program order, writing the register file, releasing stores, and resolving branch predictions.
- Flush: on a mispredicted branch it empties itself and broadcasts a one-cycle flush with the redirect PC.

---
 rtl/reorder_buffer_if.sv | 59 +++++
 rtl/reorder_buffer.sv | 212 +++++++++++++++++++++
 tb/tb_reorder_buffer.sv | 372 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reorder_buffer_if.sv
// Issue, result-broadcast, query and commit signals of the reorder buffer.
// master = core side (instruction unit, RS, LSB, register file); slave = the ROB itself.
interface reorder_buffer_if #(
    parameter int ROB_WIDTH = 4,
    parameter int REG_WIDTH = 5
);
    logic                 issueValid;
    logic [1:0]           issueType;
    logic [REG_WIDTH-1:0] issueDest;
    logic                 issueReady;
    logic [31:0]          issueVal;
    logic                 issuePredTaken;
    logic [31:0]          issueAltPc;
    logic                 full;
    logic [ROB_WIDTH-1:0] tailId;

    logic [ROB_WIDTH-1:0] query1Id;
    logic [ROB_WIDTH-1:0] query2Id;
    logic                 query1Ready;
    logic                 query2Ready;
    logic [31:0]          query1Val;
    logic [31:0]          query2Val;

    logic                 rsUpdate;
    logic [ROB_WIDTH-1:0] rsRobId;
    logic [31:0]          rsVal;
    logic                 lsbUpdate;
    logic [ROB_WIDTH-1:0] lsbRobId;
    logic [31:0]          lsbVal;

    logic                 regWrite;
    logic [REG_WIDTH-1:0] regWriteId;
    logic [31:0]          regWriteVal;
    logic [ROB_WIDTH-1:0] regWriteRobId;
    logic                 storeCommit;
    logic [ROB_WIDTH-1:0] storeCommitRobId;
    logic                 flush;
    logic [31:0]          flushPc;

    modport master (
        output issueValid, issueType, issueDest, issueReady, issueVal,
               issuePredTaken, issueAltPc,
               query1Id, query2Id,
               rsUpdate, rsRobId, rsVal, lsbUpdate, lsbRobId, lsbVal,
        input  full, tailId, query1Ready, query2Ready, query1Val, query2Val,
               regWrite, regWriteId, regWriteVal, regWriteRobId,
               storeCommit, storeCommitRobId, flush, flushPc
    );

    modport slave (
        input  issueValid, issueType, issueDest, issueReady, issueVal,
               issuePredTaken, issueAltPc,
               query1Id, query2Id,
               rsUpdate, rsRobId, rsVal, lsbUpdate, lsbRobId, lsbVal,
        output full, tailId, query1Ready, query2Ready, query1Val, query2Val,
               regWrite, regWriteId, regWriteVal, regWriteRobId,
               storeCommit, storeCommitRobId, flush, flushPc
    );
endinterface

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocates at issue, captures RS/LSB results, commits in order, flushes on mispredict.
// Optional ROB_BYPASS_EN: query ports forward same-cycle RS/LSB broadcasts (LSB has priority).
module reorder_buffer #(
    parameter int ROB_WIDTH = 4,
    parameter int REG_WIDTH = 5
) (
    input  logic            clockIn,
    input  logic            resetIn,
    reorder_buffer_if.slave rob
);
    localparam int DEPTH = 1 << ROB_WIDTH;
    localparam logic [ROB_WIDTH:0] CNT_MAX  = (ROB_WIDTH+1)'(DEPTH);
    localparam logic [ROB_WIDTH:0] CNT_FULL = (ROB_WIDTH+1)'(DEPTH - 1);

    typedef enum logic [1:0] {
        TYPE_REG    = 2'b00,
        TYPE_STORE  = 2'b01,
        TYPE_BRANCH = 2'b10,
        TYPE_NOP    = 2'b11
    } entry_type_e;

    logic [DEPTH-1:0]     valid_q, valid_d;
    logic [DEPTH-1:0]     ready_q, ready_d;
    logic [DEPTH-1:0]     pred_q, pred_d;
    entry_type_e          type_q [DEPTH];
    entry_type_e          type_d [DEPTH];
    logic [REG_WIDTH-1:0] dest_q [DEPTH];
    logic [REG_WIDTH-1:0] dest_d [DEPTH];
    logic [31:0]          value_q [DEPTH];
    logic [31:0]          value_d [DEPTH];
    logic [31:0]          alt_pc_q [DEPTH];
    logic [31:0]          alt_pc_d [DEPTH];

    logic [ROB_WIDTH-1:0] head_q, head_d;
    logic [ROB_WIDTH-1:0] tail_q, tail_d;
    logic [ROB_WIDTH:0]   count_q, count_d;

    logic                 reg_write_q, reg_write_d;
    logic [REG_WIDTH-1:0] reg_write_id_q, reg_write_id_d;
    logic [31:0]          reg_write_val_q, reg_write_val_d;
    logic [ROB_WIDTH-1:0] reg_write_rob_id_q, reg_write_rob_id_d;
    logic                 store_commit_q, store_commit_d;
    logic [ROB_WIDTH-1:0] store_commit_rob_id_q, store_commit_rob_id_d;
    logic                 flush_q, flush_d;
    logic [31:0]          flush_pc_q, flush_pc_d;

    logic issue_accept;
    logic head_done;
    logic mispredict;
    logic rs_capture;
    logic lsb_capture;

    always_comb begin
        issue_accept = rob.issueValid && (count_q != CNT_MAX);
        head_done    = valid_q[head_q] && ready_q[head_q];
        mispredict   = head_done && (type_q[head_q] == TYPE_BRANCH) &&
                       (value_q[head_q][0] != pred_q[head_q]);
        rs_capture   = rob.rsUpdate && valid_q[rob.rsRobId] && !ready_q[rob.rsRobId];
        lsb_capture  = rob.lsbUpdate && valid_q[rob.lsbRobId] && !ready_q[rob.lsbRobId];
    end

    always_comb begin
        valid_d  = valid_q;
        ready_d  = ready_q;
        pred_d   = pred_q;
        type_d   = type_q;
        dest_d   = dest_q;
        value_d  = value_q;
        alt_pc_d = alt_pc_q;
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;

        reg_write_d           = 1'b0;
        reg_write_id_d        = '0;
        reg_write_val_d       = '0;
        reg_write_rob_id_d    = '0;
        store_commit_d        = 1'b0;
        store_commit_rob_id_d = '0;
        flush_d               = 1'b0;
        flush_pc_d            = '0;

        if (mispredict) begin
            // Everything younger than the branch is wrong-path work; drop it all.
            valid_d    = '0;
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            flush_d    = 1'b1;
            flush_pc_d = alt_pc_q[head_q];
        end else begin
            if (rs_capture) begin
                ready_d[rob.rsRobId] = 1'b1;
                value_d[rob.rsRobId] = rob.rsVal;
            end
            // Applied after RS so the LSB value wins when both hit one entry.
            if (lsb_capture) begin
                ready_d[rob.lsbRobId] = 1'b1;
                value_d[rob.lsbRobId] = rob.lsbVal;
            end

            if (issue_accept) begin
                valid_d[tail_q]  = 1'b1;
                ready_d[tail_q]  = rob.issueReady;
                pred_d[tail_q]   = rob.issuePredTaken;
                type_d[tail_q]   = entry_type_e'(rob.issueType);
                dest_d[tail_q]   = rob.issueDest;
                value_d[tail_q]  = rob.issueVal;
                alt_pc_d[tail_q] = rob.issueAltPc;
                tail_d           = tail_q + 1'b1;
            end

            if (head_done) begin
                valid_d[head_q] = 1'b0;
                head_d          = head_q + 1'b1;
                unique case (type_q[head_q])
                    TYPE_REG: begin
                        if (dest_q[head_q] != '0) begin
                            reg_write_d        = 1'b1;
                            reg_write_id_d     = dest_q[head_q];
                            reg_write_val_d    = value_q[head_q];
                            reg_write_rob_id_d = head_q;
                        end
                    end
                    TYPE_STORE: begin
                        store_commit_d        = 1'b1;
                        store_commit_rob_id_d = head_q;
                    end
                    default: ;
                endcase
            end

            count_d = count_q + (ROB_WIDTH+1)'(issue_accept) - (ROB_WIDTH+1)'(head_done);
        end
    end

    always_ff @(posedge clockIn or negedge resetIn) begin
        if (!resetIn) begin
            valid_q <= '0;
            ready_q <= '0;
            pred_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                type_q[i]   <= TYPE_REG;
                dest_q[i]   <= '0;
                value_q[i]  <= '0;
                alt_pc_q[i] <= '0;
            end
            head_q                <= '0;
            tail_q                <= '0;
            count_q               <= '0;
            reg_write_q           <= 1'b0;
            reg_write_id_q        <= '0;
            reg_write_val_q       <= '0;
            reg_write_rob_id_q    <= '0;
            store_commit_q        <= 1'b0;
            store_commit_rob_id_q <= '0;
            flush_q               <= 1'b0;
            flush_pc_q            <= '0;
        end else begin
            valid_q               <= valid_d;
            ready_q               <= ready_d;
            pred_q                <= pred_d;
            type_q                <= type_d;
            dest_q                <= dest_d;
            value_q               <= value_d;
            alt_pc_q              <= alt_pc_d;
            head_q                <= head_d;
            tail_q                <= tail_d;
            count_q               <= count_d;
            reg_write_q           <= reg_write_d;
            reg_write_id_q        <= reg_write_id_d;
            reg_write_val_q       <= reg_write_val_d;
            reg_write_rob_id_q    <= reg_write_rob_id_d;
            store_commit_q        <= store_commit_d;
            store_commit_rob_id_q <= store_commit_rob_id_d;
            flush_q               <= flush_d;
            flush_pc_q            <= flush_pc_d;
        end
    end

    // Returns {ready, value}; an absent or pending entry reads as all zeros.
    function automatic logic [32:0] lookup(input logic [ROB_WIDTH-1:0] id);
        logic [32:0] res;
        res = '0;
        if (valid_q[id] && ready_q[id]) begin
            res = {1'b1, value_q[id]};
        end
`ifdef ROB_BYPASS_EN
        else if (valid_q[id] && rob.lsbUpdate && (rob.lsbRobId == id)) begin
            res = {1'b1, rob.lsbVal};
        end else if (valid_q[id] && rob.rsUpdate && (rob.rsRobId == id)) begin
            res = {1'b1, rob.rsVal};
        end
`endif
        return res;
    endfunction

    assign {rob.query1Ready, rob.query1Val} = lookup(rob.query1Id);
    assign {rob.query2Ready, rob.query2Val} = lookup(rob.query2Id);

    assign rob.full             = (count_q >= CNT_FULL);
    assign rob.tailId           = tail_q;
    assign rob.regWrite         = reg_write_q;
    assign rob.regWriteId       = reg_write_id_q;
    assign rob.regWriteVal      = reg_write_val_q;
    assign rob.regWriteRobId    = reg_write_rob_id_q;
    assign rob.storeCommit      = store_commit_q;
    assign rob.storeCommitRobId = store_commit_rob_id_q;
    assign rob.flush            = flush_q;
    assign rob.flushPc          = flush_pc_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a queue-based program-order model.
module tb_reorder_buffer;
    localparam int RW = 4;
    localparam int GW = 5;
    localparam int N  = 16;

    logic clk;
    logic rst_n;

    reorder_buffer_if #(.ROB_WIDTH(RW), .REG_WIDTH(GW)) rif ();

    reorder_buffer #(.ROB_WIDTH(RW), .REG_WIDTH(GW)) dut (
        .clockIn (clk),
        .resetIn (rst_n),
        .rob     (rif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // Model: program-order queue of live tags plus per-tag payload.
    int          order[$];
    int          m_tail;
    bit          m_rdy  [N];
    logic [31:0] m_val  [N];
    logic [31:0] m_alt  [N];
    logic [1:0]  m_typ  [N];
    logic [4:0]  m_dest [N];
    bit          m_pred [N];

    bit          e_rw, e_sc, e_fl;
    logic [4:0]  e_rwid;
    logic [31:0] e_rwval, e_flpc;
    int          e_rwrob, e_scid;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit in_rob(input int id);
        foreach (order[i]) if (order[i] == id) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [32:0] exp_query(input int id);
        logic [32:0] r;
        r = '0;
        if (in_rob(id)) begin
            if (m_rdy[id]) r = {1'b1, m_val[id]};
`ifdef ROB_BYPASS_EN
            else if (rif.lsbUpdate && int'(rif.lsbRobId) == id) r = {1'b1, rif.lsbVal};
            else if (rif.rsUpdate && int'(rif.rsRobId) == id) r = {1'b1, rif.rsVal};
`endif
        end
        return r;
    endfunction

    task automatic model_clear();
        order.delete();
        m_tail = 0;
        for (int i = 0; i < N; i++) m_rdy[i] = 1'b0;
        e_rw = 0; e_sc = 0; e_fl = 0;
        e_rwid = 0; e_rwval = 0; e_flpc = 0; e_rwrob = 0; e_scid = 0;
    endtask

    task automatic model_step();
        int  sz, head, rid, lid;
        bit  com, rs_ok, lsb_ok;
        e_rw = 0; e_sc = 0; e_fl = 0;
        e_rwid = 0; e_rwval = 0; e_flpc = 0; e_rwrob = 0; e_scid = 0;
        sz   = order.size();
        com  = (sz > 0) && m_rdy[order[0]];
        head = (sz > 0) ? order[0] : 0;
        if (com && m_typ[head] == 2'b10 && m_val[head][0] != m_pred[head]) begin
            e_fl   = 1;
            e_flpc = m_alt[head];
            order.delete();
            m_tail = 0;
            return;
        end
        rid    = int'(rif.rsRobId);
        lid    = int'(rif.lsbRobId);
        rs_ok  = rif.rsUpdate && in_rob(rid) && !m_rdy[rid];
        lsb_ok = rif.lsbUpdate && in_rob(lid) && !m_rdy[lid];
        if (rs_ok) begin m_rdy[rid] = 1; m_val[rid] = rif.rsVal; end
        if (lsb_ok) begin m_rdy[lid] = 1; m_val[lid] = rif.lsbVal; end
        if (rif.issueValid && sz < N) begin
            m_typ[m_tail]  = rif.issueType;
            m_dest[m_tail] = rif.issueDest;
            m_rdy[m_tail]  = rif.issueReady;
            m_val[m_tail]  = rif.issueVal;
            m_pred[m_tail] = rif.issuePredTaken;
            m_alt[m_tail]  = rif.issueAltPc;
            order.push_back(m_tail);
            m_tail = (m_tail + 1) % N;
        end
        if (com) begin
            void'(order.pop_front());
            if (m_typ[head] == 2'b00 && m_dest[head] != 0) begin
                e_rw = 1; e_rwid = m_dest[head]; e_rwval = m_val[head]; e_rwrob = head;
            end else if (m_typ[head] == 2'b01) begin
                e_sc = 1; e_scid = head;
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_clear();
        else        model_step();
    end

    always @(negedge clk) begin
        logic [32:0] q1, q2;
        if (rst_n && cmp_en) begin
            q1 = exp_query(int'(rif.query1Id));
            q2 = exp_query(int'(rif.query2Id));
            chk("full",        32'(rif.full),        32'(order.size() >= N - 1));
            chk("tailId",      32'(rif.tailId),      32'(m_tail));
            chk("regWrite",    32'(rif.regWrite),    32'(e_rw));
            chk("storeCommit", 32'(rif.storeCommit), 32'(e_sc));
            chk("flush",       32'(rif.flush),       32'(e_fl));
            if (e_rw) begin
                chk("regWriteId",    32'(rif.regWriteId),    32'(e_rwid));
                chk("regWriteVal",   rif.regWriteVal,        e_rwval);
                chk("regWriteRobId", 32'(rif.regWriteRobId), 32'(e_rwrob));
            end
            if (e_sc) chk("storeCommitRobId", 32'(rif.storeCommitRobId), 32'(e_scid));
            if (e_fl) chk("flushPc", rif.flushPc, e_flpc);
            chk("query1Ready", 32'(rif.query1Ready), 32'(q1[32]));
            chk("query1Val",   rif.query1Val,        q1[31:0]);
            chk("query2Ready", 32'(rif.query2Ready), 32'(q2[32]));
            chk("query2Val",   rif.query2Val,        q2[31:0]);
        end
    end

    task automatic clear_inputs();
        rif.issueValid = 0; rif.issueType = 0; rif.issueDest = 0; rif.issueReady = 0;
        rif.issueVal = 0; rif.issuePredTaken = 0; rif.issueAltPc = 0;
        rif.query1Id = 0; rif.query2Id = 0;
        rif.rsUpdate = 0; rif.rsRobId = 0; rif.rsVal = 0;
        rif.lsbUpdate = 0; rif.lsbRobId = 0; rif.lsbVal = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
    endtask

    task automatic issue(input logic [1:0] t, input logic [4:0] d, input bit rdy,
                         input logic [31:0] v, input bit p, input logic [31:0] alt);
        rif.issueValid = 1; rif.issueType = t; rif.issueDest = d; rif.issueReady = rdy;
        rif.issueVal = v; rif.issuePredTaken = p; rif.issueAltPc = alt;
    endtask

    task automatic rand_drive(input int rate);
        int r;
        clear_inputs();
        if ($urandom_range(3) < rate) begin
            r = $urandom_range(23);
            issue((r == 0) ? 2'b10 : (r < 4) ? 2'b01 : (r < 6) ? 2'b11 : 2'b00,
                  5'($urandom_range(31)), ($urandom_range(2) == 0),
                  $urandom, 1'($urandom_range(1)), $urandom);
        end
        if ($urandom_range(1) == 1) begin
            rif.rsUpdate = 1;
            rif.rsRobId  = (order.size() > 0 && $urandom_range(3) != 0) ?
                           4'(order[$urandom_range(order.size() - 1)]) : 4'($urandom_range(N - 1));
            rif.rsVal    = $urandom;
        end
        if ($urandom_range(4) < 2) begin
            rif.lsbUpdate = 1;
            rif.lsbRobId  = ($urandom_range(3) == 0) ? rif.rsRobId :
                            (order.size() > 0) ? 4'(order[$urandom_range(order.size() - 1)]) :
                            4'($urandom_range(N - 1));
            rif.lsbVal    = $urandom;
        end
        rif.query1Id = (order.size() > 0 && $urandom_range(1) == 0) ?
                       4'(order[$urandom_range(order.size() - 1)]) : 4'($urandom_range(N - 1));
        rif.query2Id = 4'($urandom_range(N - 1));
    endtask

    initial begin
        int rate;
        clear_inputs();
        rst_n = 0;
        #3;
        chk("rst_full",        32'(rif.full),        32'd0);
        chk("rst_tailId",      32'(rif.tailId),      32'd0);
        chk("rst_regWrite",    32'(rif.regWrite),    32'd0);
        chk("rst_storeCommit", 32'(rif.storeCommit), 32'd0);
        chk("rst_flush",       32'(rif.flush),       32'd0);
        chk("rst_query1Ready", 32'(rif.query1Ready), 32'd0);
        tick();
        rst_n  = 1;
        cmp_en = 1;

        // Single REG entry completed by RS, committed two cycles after the update.
        do_reset();
        issue(2'b00, 5'd5, 0, 0, 0, 0);
        tick();
        clear_inputs();
        rif.rsUpdate = 1; rif.rsRobId = 0; rif.rsVal = 32'h1234;
        tick();
        clear_inputs();
        chk("d1_early", 32'(rif.regWrite), 32'd0);
        tick();
        chk("d1_regWrite",    32'(rif.regWrite),      32'd1);
        chk("d1_regWriteId",  32'(rif.regWriteId),    32'd5);
        chk("d1_regWriteVal", rif.regWriteVal,        32'h1234);
        chk("d1_robId",       32'(rif.regWriteRobId), 32'd0);
        tick();
        chk("d1_pulse", 32'(rif.regWrite), 32'd0);

        // Out-of-order completion, in-order retirement on consecutive cycles.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            issue(2'b00, 5'(i + 1), 0, 0, 0, 0);
            tick();
        end
        clear_inputs();
        for (int i = 2; i >= 0; i--) begin
            rif.rsUpdate = 1; rif.rsRobId = 4'(i); rif.rsVal = 32'(100 + i);
            tick();
            chk("d2_noearly", 32'(rif.regWrite), 32'd0);
        end
        clear_inputs();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("d2_regWrite", 32'(rif.regWrite),      32'd1);
            chk("d2_robId",    32'(rif.regWriteRobId), 32'(i));
            chk("d2_val",      rif.regWriteVal,        32'(100 + i));
        end
        tick();
        chk("d2_done", 32'(rif.regWrite), 32'd0);

        // Fill to 15 and 16, overflow ignored, commit at full with a blocked issue.
        do_reset();
        for (int i = 0; i < 15; i++) begin
            issue(2'b00, 5'd1, 0, 0, 0, 0);
            tick();
        end
        chk("d3_full15", 32'(rif.full),   32'd1);
        chk("d3_tail15", 32'(rif.tailId), 32'd15);
        tick();
        chk("d3_tail16", 32'(rif.tailId), 32'd0);
        tick();
        chk("d3_tail17", 32'(rif.tailId), 32'd0);
        rif.rsUpdate = 1; rif.rsRobId = 0; rif.rsVal = 32'h55;
        tick();
        rif.rsUpdate = 0;
        tick();
        chk("d3_commit",   32'(rif.regWrite),      32'd1);
        chk("d3_commitId", 32'(rif.regWriteRobId), 32'd0);
        chk("d3_tailHeld", 32'(rif.tailId),        32'd0);
        chk("d3_fullHeld", 32'(rif.full),          32'd1);
        tick();
        chk("d3_tailNext", 32'(rif.tailId), 32'd1);
        chk("d3_fullNext", 32'(rif.full),   32'd1);
        clear_inputs();

        // Mispredicted branch: flush pulse, younger entries dropped.
        do_reset();
        issue(2'b10, 5'd0, 0, 0, 1, 32'h100);
        tick();
        issue(2'b00, 5'd3, 0, 0, 0, 0);
        tick();
        issue(2'b00, 5'd4, 1, 32'h44, 0, 0);
        tick();
        clear_inputs();
        rif.rsUpdate = 1; rif.rsRobId = 0; rif.rsVal = 0;
        tick();
        clear_inputs();
        rif.query1Id = 2;
        tick();
        chk("d4_flush",    32'(rif.flush),       32'd1);
        chk("d4_flushPc",  rif.flushPc,          32'h100);
        chk("d4_tailId",   32'(rif.tailId),      32'd0);
        chk("d4_noWrite",  32'(rif.regWrite),    32'd0);
        chk("d4_q1Ready",  32'(rif.query1Ready), 32'd0);
        tick();
        chk("d4_flushEnd", 32'(rif.flush),    32'd0);
        chk("d4_noWrite2", 32'(rif.regWrite), 32'd0);

        // STORE then REG to r0; head moves to 2.
        do_reset();
        issue(2'b01, 5'd0, 1, 32'h9, 0, 0);
        tick();
        issue(2'b00, 5'd0, 1, 32'h7, 0, 0);
        tick();
        clear_inputs();
        chk("d5_store",   32'(rif.storeCommit),      32'd1);
        chk("d5_storeId", 32'(rif.storeCommitRobId), 32'd0);
        tick();
        chk("d5_noReg",   32'(rif.regWrite),    32'd0);
        chk("d5_noStore", 32'(rif.storeCommit), 32'd0);
        issue(2'b00, 5'd9, 1, 32'hAB, 0, 0);
        tick();
        clear_inputs();
        tick();
        chk("d5_head2",   32'(rif.regWriteRobId), 32'd2);
        chk("d5_head2wr", 32'(rif.regWrite),      32'd1);

        // Query racing an LSB broadcast.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            issue(2'b00, 5'd1, 0, 0, 0, 0);
            tick();
        end
        clear_inputs();
        rif.query1Id = 3; rif.lsbUpdate = 1; rif.lsbRobId = 3; rif.lsbVal = 7;
        #1;
`ifdef ROB_BYPASS_EN
        chk("d6_sameReady", 32'(rif.query1Ready), 32'd1);
        chk("d6_sameVal",   rif.query1Val,        32'd7);
`else
        chk("d6_sameReady", 32'(rif.query1Ready), 32'd0);
        chk("d6_sameVal",   rif.query1Val,        32'd0);
`endif
        tick();
        rif.lsbUpdate = 0;
        #1;
        chk("d6_nextReady", 32'(rif.query1Ready), 32'd1);
        chk("d6_nextVal",   rif.query1Val,        32'd7);

        // Randomized traffic against the model.
        do_reset();
        rate = 3;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 256 == 0) rate = $urandom_range(1, 4);
            rand_drive(rate);
            tick();
            if (cyc == 1500) begin
                rst_n = 0;
                #1;
                chk("mid_full",     32'(rif.full),        32'd0);
                chk("mid_tailId",   32'(rif.tailId),      32'd0);
                chk("mid_regWrite", 32'(rif.regWrite),    32'd0);
                chk("mid_store",    32'(rif.storeCommit), 32'd0);
                chk("mid_flush",    32'(rif.flush),       32'd0);
                clear_inputs();
                tick();
                rst_n = 1;
            end
        end
        clear_inputs();
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
